// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache tag controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default widths, tag-entry bit layout, controller FSM state enum,
// and a packed view of one tag entry for code that wants named fields.
package dcache_pkg;

  // Default geometry: 16 sets, 22-bit stored tag, 24-bit tag-array word.
  localparam int DC_SET_W   = 4;
  localparam int DC_TAG_W   = 22;
  localparam int DC_ENTRY_W = 24;

  // Tag-array word layout: {valid, dirty, tag}.
  localparam int DC_V_BIT    = 23;
  localparam int DC_D_BIT    = 22;
  localparam int DC_TAG_LSB  = 0;

  // INIT sweeps the array to all-zero entries; IDLE serves traffic.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } dc_state_e;

  // Named-field view of an entry at the default geometry.
  typedef struct packed {
    logic                v;
    logic                d;
    logic [DC_TAG_W-1:0] tag;
  } dc_entry_t;

endpackage

// File: rtl/dcache_tag_ctrl.sv
// Tag controller for a direct-mapped data cache: lookups, tag updates and a
// full-array invalidation sweep against an external single-port tag SRAM.
// Latency: lookup response 2 cycles after acceptance; writes produce no response.
// Backpressure: lk/wr ready low during sweep and reset; writes win over lookups.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   lk_valid/lk_ready/lk_set/lk_tag  lookup request channel
//   resp_valid/resp_hit/resp_dirty/resp_tag  registered lookup response
//   wr_valid/wr_ready/wr_set/wr_tag/wr_v/wr_d  tag update channel
//   inv_all, busy                invalidate-all pulse, sweep-in-progress flag
//   sram_csb/sram_web/sram_addr/sram_din/sram_dout  tag SRAM command/data
module dcache_tag_ctrl
  import dcache_pkg::*;
#(
  parameter int SET_W   = DC_SET_W,
  parameter int TAG_W   = DC_TAG_W,
  parameter int ENTRY_W = DC_ENTRY_W
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [SET_W-1:0]   lk_set,
  input  logic [TAG_W-1:0]   lk_tag,

  output logic               resp_valid,
  output logic               resp_hit,
  output logic               resp_dirty,
  output logic [TAG_W-1:0]   resp_tag,

  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [SET_W-1:0]   wr_set,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_v,
  input  logic               wr_d,

  input  logic               inv_all,
  output logic               busy,

  output logic               sram_csb,
  output logic               sram_web,
  output logic [SET_W-1:0]   sram_addr,
  output logic [ENTRY_W-1:0] sram_din,
  input  logic [ENTRY_W-1:0] sram_dout
);

  localparam logic [SET_W-1:0] SWEEP_LAST = '1;

  dc_state_e        state_q;
  logic [SET_W-1:0] sweep_q;

  // Lookup pipeline: stage 1 holds the compare tag while the SRAM reads,
  // stage 2 is the registered response.
  logic             rd_pend_q;
  logic [TAG_W-1:0] lk_tag_q;
  logic             resp_valid_q;
  logic             resp_hit_q;
  logic             resp_dirty_q;
  logic [TAG_W-1:0] resp_tag_q;

  logic             is_idle;
  logic             lk_fire;
  logic             wr_fire;

  logic             ent_v;
  logic             ent_d;
  logic [TAG_W-1:0] ent_tag;

  // Handshakes. Reset gates the readies directly so nothing is accepted
  // while rst is high, independent of the state register's current value.
  assign is_idle  = (state_q == ST_IDLE) && !rst;
  assign wr_ready = is_idle;
  assign lk_ready = is_idle && !wr_valid;
  assign busy     = rst || (state_q == ST_INIT);

  assign wr_fire  = wr_valid && wr_ready;
  assign lk_fire  = lk_valid && lk_ready;

  // SRAM command is combinational so the macro captures it at the same edge
  // that accepts the request. Sweep writes own the port in INIT.
  always_comb begin
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        sram_csb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = sweep_q;
      end else if (wr_fire) begin
        sram_csb                        = 1'b0;
        sram_web                        = 1'b0;
        sram_addr                       = wr_set;
        sram_din[DC_V_BIT]              = wr_v;
        sram_din[DC_D_BIT]              = wr_d;
        sram_din[DC_TAG_LSB +: TAG_W]   = wr_tag;
      end else if (lk_fire) begin
        sram_csb  = 1'b0;
        sram_addr = lk_set;
      end
    end
  end

  // Read data is valid during the cycle after the read is captured, which is
  // exactly when rd_pend_q is high.
  assign ent_v   = sram_dout[DC_V_BIT];
  assign ent_d   = sram_dout[DC_D_BIT];
  assign ent_tag = sram_dout[DC_TAG_LSB +: TAG_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      rd_pend_q    <= 1'b0;
      lk_tag_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_dirty_q <= 1'b0;
      resp_tag_q   <= '0;
    end else begin
      // Lookup pipeline runs regardless of state so a lookup accepted just
      // before an inv_all still delivers its response.
      rd_pend_q    <= lk_fire;
      resp_valid_q <= rd_pend_q;
      if (lk_fire) begin
        lk_tag_q <= lk_tag;
      end
      if (rd_pend_q) begin
        resp_hit_q   <= ent_v && (ent_tag == lk_tag_q);
        resp_dirty_q <= ent_d;
        resp_tag_q   <= ent_tag;
      end

      case (state_q)
        ST_INIT: begin
          if (inv_all) begin
            sweep_q <= '0;
          end else if (sweep_q == SWEEP_LAST) begin
            // Write to the last set is issued this cycle; leave next edge.
            state_q <= ST_IDLE;
            sweep_q <= '0;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (inv_all) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          sweep_q <= '0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_dirty = resp_dirty_q;
  assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl with a behavioural tag SRAM and write log.
// Latency: checks lookup responses two cycles after acceptance.
// Backpressure: drives one request per cycle; expects writes to win over lookups.
module tb_dcache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid;
  logic        lk_ready;
  logic [3:0]  lk_set;
  logic [21:0] lk_tag;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_dirty;
  logic [21:0] resp_tag;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_set;
  logic [21:0] wr_tag;
  logic        wr_v;
  logic        wr_d;
  logic        inv_all;
  logic        busy;
  logic        sram_csb;
  logic        sram_web;
  logic [3:0]  sram_addr;
  logic [23:0] sram_din;
  logic [23:0] sram_dout;

  always #5 clk = ~clk;

  dcache_tag_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .lk_valid   (lk_valid),
    .lk_ready   (lk_ready),
    .lk_set     (lk_set),
    .lk_tag     (lk_tag),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_dirty (resp_dirty),
    .resp_tag   (resp_tag),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_set     (wr_set),
    .wr_tag     (wr_tag),
    .wr_v       (wr_v),
    .wr_d       (wr_d),
    .inv_all    (inv_all),
    .busy       (busy),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Tag SRAM: command captured at the edge; read data held until next read.
  // A write at edge N is visible to a read captured at edge N+1.
  logic [23:0] mem [16];
  logic [3:0]  log_addr[$];
  logic [23:0] log_din[$];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 24'hFFFFFF;
    sram_dout = 24'h0;
  end

  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        mem[sram_addr] <= sram_din;
        log_addr.push_back(sram_addr);
        log_din.push_back(sram_din);
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lk_valid = 1'b0;
    wr_valid = 1'b0;
    inv_all  = 1'b0;
  endtask

  // Called on the first cycle of a sweep; counts busy cycles and checks the
  // write sequence issued to the SRAM.
  task automatic check_sweep(input string nm);
    int n;
    bit ok;
    log_addr.delete();
    log_din.delete();
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk({nm, "_busy_cycles"}, n, 16);
    chk({nm, "_write_count"}, log_addr.size(), 16);
    ok = (log_addr.size() == 16);
    for (int i = 0; i < log_addr.size() && i < 16; i++)
      if (log_addr[i] != i[3:0] || log_din[i] != 24'h0) ok = 1'b0;
    chk({nm, "_write_order"}, ok, 1);
    chk({nm, "_lk_ready_after"}, lk_ready, 1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [3:0]  set;
    logic [21:0] tag;
    bit          v;
    bit          d;
    bit          e_hit;
    bit          e_dirty;
    logic [21:0] e_tag;
  } vec_t;

  vec_t vecs[13];

  // Bench-side copy of the array contents, maintained from stimulus only.
  bit          sh_v[16];
  bit          sh_d[16];
  logic [21:0] sh_tag[16];

  initial begin
    logic [21:0] used_tag[16];

    vecs[0]  = '{1'b1, 4'd3,  22'h012345, 1'b1, 1'b0, 1'b0, 1'b0, 22'h0};
    vecs[1]  = '{1'b0, 4'd3,  22'h012345, 1'b0, 1'b0, 1'b1, 1'b0, 22'h012345};
    vecs[2]  = '{1'b0, 4'd3,  22'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 22'h012345};
    vecs[3]  = '{1'b1, 4'd7,  22'h3FFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 22'h0};
    vecs[4]  = '{1'b0, 4'd7,  22'h3FFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 22'h3FFFFF};
    vecs[5]  = '{1'b0, 4'd7,  22'h3FFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 22'h3FFFFF};
    vecs[6]  = '{1'b1, 4'd9,  22'h000AAA, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0};
    vecs[7]  = '{1'b0, 4'd9,  22'h000AAA, 1'b0, 1'b0, 1'b0, 1'b1, 22'h000AAA};
    vecs[8]  = '{1'b0, 4'd0,  22'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0};
    vecs[9]  = '{1'b1, 4'd15, 22'h2ABCDE, 1'b1, 1'b0, 1'b0, 1'b0, 22'h0};
    vecs[10] = '{1'b0, 4'd15, 22'h2ABCDE, 1'b0, 1'b0, 1'b1, 1'b0, 22'h2ABCDE};
    vecs[11] = '{1'b1, 4'd3,  22'h012345, 1'b1, 1'b1, 1'b0, 1'b0, 22'h0};
    vecs[12] = '{1'b0, 4'd3,  22'h012345, 1'b0, 1'b0, 1'b1, 1'b1, 22'h012345};

    for (int i = 0; i < 16; i++) begin
      sh_v[i] = 1'b0; sh_d[i] = 1'b0; sh_tag[i] = 22'h0;
    end

    idle();
    lk_set = 4'd0; lk_tag = 22'h0;
    wr_set = 4'd0; wr_tag = 22'h0; wr_v = 1'b0; wr_d = 1'b0;

    // ---- reset values ----
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_busy",       busy,       1);
    chk("rst_lk_ready",   lk_ready,   0);
    chk("rst_wr_ready",   wr_ready,   0);
    chk("rst_csb",        sram_csb,   1);
    chk("rst_web",        sram_web,   1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit",   resp_hit,   0);
    chk("rst_resp_dirty", resp_dirty, 0);
    chk("rst_resp_tag",   resp_tag,   0);

    // ---- initial sweep ----
    rst = 1'b0;
    check_sweep("init_sweep");
    chk("idle_wr_ready", wr_ready, 1);
    chk("idle_csb",      sram_csb, 1);

    // ---- table: one op per cycle, response checked two edges later ----
    for (int i = 0; i <= 13; i++) begin
      idle();
      if (i < 13) begin
        if (vecs[i].is_wr) begin
          wr_valid = 1'b1; wr_set = vecs[i].set; wr_tag = vecs[i].tag;
          wr_v = vecs[i].v; wr_d = vecs[i].d;
          sh_v[vecs[i].set] = vecs[i].v;
          sh_d[vecs[i].set] = vecs[i].d;
          sh_tag[vecs[i].set] = vecs[i].tag;
        end else begin
          lk_valid = 1'b1; lk_set = vecs[i].set; lk_tag = vecs[i].tag;
        end
      end
      tick();
      if (i >= 1) begin
        if (vecs[i-1].is_wr) begin
          chk($sformatf("vec%0d_no_resp", i-1), resp_valid, 0);
        end else begin
          chk($sformatf("vec%0d_resp_valid", i-1), resp_valid, 1);
          chk($sformatf("vec%0d_hit", i-1),   resp_hit,   vecs[i-1].e_hit);
          chk($sformatf("vec%0d_dirty", i-1), resp_dirty, vecs[i-1].e_dirty);
          chk($sformatf("vec%0d_tag", i-1),   resp_tag,   vecs[i-1].e_tag);
        end
      end
    end
    idle();
    tick();
    chk("vec_tail_no_resp", resp_valid, 0);

    // ---- back-to-back lookups of every set ----
    for (int i = 0; i <= 16; i++) begin
      idle();
      if (i < 16) begin
        used_tag[i] = sh_v[i] ? sh_tag[i] : 22'h000001;
        lk_valid = 1'b1; lk_set = i[3:0]; lk_tag = used_tag[i];
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("b2b%0d_resp_valid", i-1), resp_valid, 1);
        chk($sformatf("b2b%0d_hit", i-1), resp_hit,
            sh_v[i-1] && (used_tag[i-1] == sh_tag[i-1]));
        chk($sformatf("b2b%0d_tag", i-1), resp_tag, sh_tag[i-1]);
      end
    end
    idle();
    tick();
    chk("b2b_tail_no_resp", resp_valid, 0);

    // ---- write and lookup in the same cycle ----
    wr_valid = 1'b1; wr_set = 4'd5; wr_tag = 22'h005555; wr_v = 1'b1; wr_d = 1'b0;
    lk_valid = 1'b1; lk_set = 4'd5; lk_tag = 22'h005555;
    #1;
    chk("coll_wr_ready", wr_ready, 1);
    chk("coll_lk_ready", lk_ready, 0);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("coll_lk_ready_next", lk_ready, 1);
    tick();
    idle();
    tick();
    chk("coll_resp_valid", resp_valid, 1);
    chk("coll_resp_hit",   resp_hit,   1);

    // ---- lookup just before inv_all still responds; then sweep ----
    tick();
    lk_valid = 1'b1; lk_set = 4'd5; lk_tag = 22'h005555;
    tick();
    idle();
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    chk("inv_pre_resp_valid", resp_valid, 1);
    chk("inv_pre_resp_hit",   resp_hit,   1);
    chk("inv_lk_ready_busy",  lk_ready,   0);
    chk("inv_wr_ready_busy",  wr_ready,   0);
    check_sweep("inv_sweep");
    lk_valid = 1'b1; lk_set = 4'd5; lk_tag = 22'h005555;
    tick();
    idle();
    tick();
    chk("inv_post_resp_valid", resp_valid, 1);
    chk("inv_post_hit",        resp_hit,   0);
    chk("inv_post_tag",        resp_tag,   0);

    // ---- reset at sweep cycle 7 restarts at set 0 ----
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    log_addr.delete();
    log_din.delete();
    rst = 1'b1;
    tick();
    chk("rst_mid_no_write", log_addr.size(), 0);
    chk("rst_mid_busy",     busy,            1);
    rst = 1'b0;
    check_sweep("rst_sweep");

    // ---- reset with a lookup in flight drops its response ----
    lk_valid = 1'b1; lk_set = 4'd2; lk_tag = 22'h0;
    tick();
    idle();
    rst = 1'b1;
    tick();
    chk("rst_lk_drop0", resp_valid, 0);
    tick();
    chk("rst_lk_drop1", resp_valid, 0);
    rst = 1'b0;
    check_sweep("final_sweep");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
